// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, LSB-first data, zero-bit insertion, optional
// CRC-16-CCITT FCS and abort sequences on a single registered serial line.
module hdlc_tx_framer #(
  parameter bit FCS_EN          = 1'b1,
  parameter int MAX_FRAME_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       TxEN,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  input  logic       Tx_Last,
  output logic       Tx_Ready,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Underrun
);

  typedef enum logic [2:0] {IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT} state_t;

  localparam int             BCW     = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [BCW-1:0] MAXB    = BCW'(MAX_FRAME_BYTES);
  localparam logic [7:0]     FLAG    = 8'h7E;
  localparam logic [7:0]     ABT_PAT = 8'hFE;

  state_t         state;
  logic [2:0]     cnt;        // index of the flag/abort bit currently on the line
  logic [15:0]    sh;         // bits not yet driven, LSB next
  logic [4:0]     left;       // number of valid bits in sh
  logic [2:0]     ones;       // run of 1s driven in DATA/FCS
  logic           stuffed;    // current line bit is an inserted 0
  logic           last_byte;
  logic [15:0]    crc;
  logic [BCW-1:0] nbytes;

  logic        slot, full, take, underrun, overflow, active, abort_req;
  logic        fcs_load, stuff, emit, crc_fb;
  logic [15:0] src, crc_next;
  logic [4:0]  src_left;

  always_comb begin
    slot      = (state == START_FLAG && cnt == 3'd7) ||
                (state == DATA && left == 5'd0 && !stuffed && !last_byte);
    full      = (nbytes == MAXB);
    Tx_Ready  = slot && !full;
    take      = Tx_Ready && Tx_Valid;
    underrun  = slot && !Tx_Valid;
    overflow  = slot && Tx_Valid && full;
    active    = (state != IDLE) && (state != ABORT);
    abort_req = active && (Tx_AbortFrame || !TxEN || underrun || overflow);
    fcs_load  = FCS_EN && state == DATA && left == 5'd0 && last_byte;
    stuff     = (ones == 3'd5);
    src       = sh;
    src_left  = left;
    if (take) begin
      src      = {8'h00, Tx_Data};
      src_left = 5'd8;
    end else if (fcs_load) begin
      src      = ~crc;
      src_left = 5'd16;
    end
    // Serialiser runs in DATA/FCS; a pending insertion is emitted before any state exit.
    emit = !abort_req &&
           ((state == START_FLAG && cnt == 3'd7) ||
            (state == DATA && !(left == 5'd0 && last_byte && !FCS_EN && !stuff)) ||
            (state == FCS && !(left == 5'd0 && !stuff)));
    crc_fb   = crc[0] ^ src[0];
    crc_next = {1'b0, crc[15:1]} ^ (crc_fb ? 16'h8408 : 16'h0000);
  end

  assign Tx_Busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      Tx              <= 1'b1;
      cnt             <= '0;
      sh              <= '0;
      left            <= '0;
      ones            <= '0;
      stuffed         <= 1'b0;
      last_byte       <= 1'b0;
      crc             <= 16'hFFFF;
      nbytes          <= '0;
      Tx_Done         <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Underrun     <= 1'b0;
    end else begin
      Tx_Done         <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Underrun     <= underrun;
      if (abort_req) begin
        state <= ABORT;
        Tx    <= ABT_PAT[0];
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            Tx <= 1'b1;
            if (TxEN && Tx_Valid) begin
              state     <= START_FLAG;
              Tx        <= FLAG[0];
              cnt       <= '0;
              ones      <= '0;
              stuffed   <= 1'b0;
              last_byte <= 1'b0;
              left      <= '0;
              crc       <= 16'hFFFF;
              nbytes    <= '0;
            end
          end
          START_FLAG: begin
            cnt <= cnt + 3'd1;
            Tx  <= FLAG[cnt + 3'd1];
            if (cnt == 3'd7) state <= DATA;
          end
          DATA: begin
            if (left == 5'd0 && last_byte) begin
              if (FCS_EN) state <= FCS;
              else if (!stuff) begin
                state <= END_FLAG;
                Tx    <= FLAG[0];
                cnt   <= '0;
              end
            end
          end
          FCS: begin
            if (left == 5'd0 && !stuff) begin
              state <= END_FLAG;
              Tx    <= FLAG[0];
              cnt   <= '0;
            end
          end
          END_FLAG: begin
            cnt <= cnt + 3'd1;
            Tx  <= FLAG[cnt + 3'd1];
            if (cnt == 3'd7) begin
              state   <= IDLE;
              Tx      <= 1'b1;
              Tx_Done <= 1'b1;
            end
          end
          ABORT: begin
            cnt <= cnt + 3'd1;
            Tx  <= ABT_PAT[cnt + 3'd1];
            if (cnt == 3'd7) begin
              state           <= IDLE;
              Tx              <= 1'b1;
              Tx_AbortedTrans <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        if (emit) begin
          if (stuff) begin
            Tx      <= 1'b0;
            ones    <= '0;
            stuffed <= 1'b1;
            sh      <= src;
            left    <= src_left;
          end else begin
            Tx      <= src[0];
            ones    <= src[0] ? ones + 3'd1 : 3'd0;
            stuffed <= 1'b0;
            sh      <= src >> 1;
            left    <= src_left - 5'd1;
            // FCS covers payload bits only
            if ((state == DATA || state == START_FLAG) && !fcs_load) crc <= crc_next;
          end
        end
        if (take) begin
          last_byte <= Tx_Last;
          nbytes    <= nbytes + BCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: FCS instance (MAX 128) and a no-FCS instance (MAX 4).
module tb_hdlc_tx_framer;
  logic       Clk = 1'b0;
  logic       Rst, TxEN, Tx_Valid, Tx_Last, Tx_AbortFrame;
  logic [7:0] Tx_Data;
  logic rdy_a, tx_a, busy_a, done_a, ab_a, un_a;
  logic rdy_b, tx_b, busy_b, done_b, ab_b, un_b;

  always #5 Clk = ~Clk;

  hdlc_tx_framer #(.FCS_EN(1'b1), .MAX_FRAME_BYTES(128)) dut (
    .Clk(Clk), .Rst(Rst), .TxEN(TxEN), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid),
    .Tx_Last(Tx_Last), .Tx_Ready(rdy_a), .Tx_AbortFrame(Tx_AbortFrame), .Tx(tx_a),
    .Tx_Busy(busy_a), .Tx_Done(done_a), .Tx_AbortedTrans(ab_a), .Tx_Underrun(un_a));

  hdlc_tx_framer #(.FCS_EN(1'b0), .MAX_FRAME_BYTES(4)) dut0 (
    .Clk(Clk), .Rst(Rst), .TxEN(TxEN), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid),
    .Tx_Last(Tx_Last), .Tx_Ready(rdy_b), .Tx_AbortFrame(Tx_AbortFrame), .Tx(tx_b),
    .Tx_Busy(busy_b), .Tx_Done(done_b), .Tx_AbortedTrans(ab_b), .Tx_Underrun(un_b));

  int total = 0, bad = 0;
  bit sel, feed;
  int hole, pidx, ncyc;
  logic [7:0] pay[$];
  bit lastq[$], busyq[$], rdyq[$];
  int doneq[$], abq[$], unq[$];
  string line, exp_s;
  string ONE = "1", ZERO = "0", FLAG_S = "01111110", ABT_S = "01111111";

  function automatic string bits8(input logic [7:0] b);
    string s = "";
    for (int i = 0; i < 8; i++) s = {s, (b[i] ? ONE : ZERO)};
    return s;
  endfunction

  task automatic drive();
    Tx_Valid = feed && (pidx < pay.size()) && (pidx != hole);
    Tx_Data  = Tx_Valid ? pay[pidx] : 8'h00;
    Tx_Last  = Tx_Valid ? lastq[pidx] : 1'b0;
  endtask

  task automatic cycle();
    logic t, r, b, d, a, u, acc;
    @(negedge Clk);
    t = sel ? tx_b : tx_a;     r = sel ? rdy_b : rdy_a;  b = sel ? busy_b : busy_a;
    d = sel ? done_b : done_a; a = sel ? ab_b : ab_a;    u = sel ? un_b : un_a;
    line = {line, (t ? ONE : ZERO)};
    busyq.push_back(b);
    rdyq.push_back(r);
    if (d) doneq.push_back(ncyc);
    if (a) abq.push_back(ncyc);
    if (u) unq.push_back(ncyc);
    acc = Tx_Valid && r;
    ncyc++;
    @(posedge Clk); #1;
    if (acc) pidx++;
    drive();
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Rst = 1'b1; feed = 1'b0; TxEN = 1'b1; Tx_AbortFrame = 1'b0;
    pidx = 0; hole = -1; pay.delete(); lastq.delete();
    drive();
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    line = ""; busyq.delete(); rdyq.delete(); doneq.delete(); abq.delete(); unq.delete();
    ncyc = 0;
  endtask

  task automatic load(input logic [7:0] b, input bit l);
    pay.push_back(b);
    lastq.push_back(l);
  endtask

  task automatic test_reset();
    int nb;
    do_reset();
    sel = 0;
    total++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++; $display("FAIL reset_state tx=%b busy=%b rdy=%b done=%b want 1 0 0 0", tx_a, busy_a, rdy_a, done_a);
    end
    TxEN = 1'b0;
    load(8'h5A, 1'b1); feed = 1'b1; drive();
    repeat (20) cycle();
    exp_s = "";
    for (int i = 0; i < 20; i++) exp_s = {exp_s, ONE};
    total++;
    if (line != exp_s) begin bad++; $display("FAIL txen_low_line got=%s want=%s", line, exp_s); end
    nb = 0;
    foreach (busyq[i]) nb += busyq[i] + rdyq[i];
    total++;
    if (nb != 0) begin bad++; $display("FAIL txen_low_busy_ready count=%0d want 0", nb); end
    total++;
    if (doneq.size() + abq.size() + unq.size() != 0) begin
      bad++; $display("FAIL txen_low_pulses count=%0d want 0", doneq.size() + abq.size() + unq.size());
    end
  endtask

  task automatic test_fcs_frame();
    logic [15:0] fcs;
    do_reset();
    sel = 0;
    for (int b = 8'h31; b <= 8'h39; b++) load(8'(b), b == 8'h39);
    feed = 1'b1; drive();
    repeat (106) cycle();
    exp_s = {ONE, FLAG_S};
    for (int b = 8'h31; b <= 8'h39; b++) exp_s = {exp_s, bits8(8'(b))};
    exp_s = {exp_s, bits8(8'h6E), bits8(8'h90), FLAG_S, ONE};
    total++;
    if (line != exp_s) begin bad++; $display("FAIL fcs_line got=%s want=%s", line, exp_s); end
    fcs = '0;
    for (int i = 0; i < 16; i++) fcs[i] = (line[81 + i] == "1");
    total++;
    if (fcs !== 16'h906E) begin bad++; $display("FAIL fcs_value got=%h want=906e", fcs); end
    total++;
    if (doneq.size() != 1 || doneq[0] != 105) begin
      bad++; $display("FAIL fcs_done pulses=%0d first=%0d want 1 at 105", doneq.size(), doneq.size() ? doneq[0] : -1);
    end
    total++;
    if (busyq[1] !== 1'b1 || busyq[104] !== 1'b1 || busyq[105] !== 1'b0) begin
      bad++; $display("FAIL fcs_busy got=%b%b%b want 110", busyq[1], busyq[104], busyq[105]);
    end
  endtask

  task automatic test_stuffing();
    int run, mx;
    do_reset();
    sel = 1;
    load(8'hFF, 1'b1);
    feed = 1'b1; drive();
    repeat (27) cycle();
    exp_s = {ONE, FLAG_S, "111110111", FLAG_S, ONE};
    total++;
    if (line != exp_s) begin bad++; $display("FAIL stuff_line got=%s want=%s", line, exp_s); end
    run = 0; mx = 0;
    for (int i = 9; i <= 17; i++) begin
      run = (line[i] == "1") ? run + 1 : 0;
      if (run > mx) mx = run;
    end
    total++;
    if (mx != 5) begin bad++; $display("FAIL stuff_maxrun got=%0d want 5", mx); end
    total++;
    if (doneq.size() != 1 || doneq[0] != 26) begin
      bad++; $display("FAIL stuff_done pulses=%0d want 1 at 26", doneq.size());
    end
  endtask

  task automatic test_abort();
    do_reset();
    sel = 0;
    load(8'h11, 0); load(8'h22, 0); load(8'h33, 0); load(8'h44, 1);
    feed = 1'b1; drive();
    for (int i = 0; i < 31; i++) begin
      Tx_AbortFrame = (i == 20);
      if (i == 20) feed = 1'b0;
      cycle();
    end
    Tx_AbortFrame = 1'b0;
    exp_s = {ONE, FLAG_S, bits8(8'h11), "0100", ABT_S, ONE, ONE};
    total++;
    if (line != exp_s) begin bad++; $display("FAIL abort_line got=%s want=%s", line, exp_s); end
    total++;
    if (abq.size() != 1 || abq[0] != 29 || doneq.size() != 0) begin
      bad++; $display("FAIL abort_pulse aborted=%0d done=%0d want 1 at 29, 0", abq.size(), doneq.size());
    end
  endtask

  task automatic test_underrun();
    do_reset();
    sel = 0;
    load(8'h55, 0); load(8'hAA, 0); load(8'h0F, 0); load(8'hF0, 1);
    hole = 1;
    feed = 1'b1; drive();
    repeat (27) cycle();
    exp_s = {ONE, FLAG_S, bits8(8'h55), ABT_S, ONE, ONE};
    total++;
    if (line != exp_s) begin bad++; $display("FAIL underrun_line got=%s want=%s", line, exp_s); end
    total++;
    if (unq.size() != 1 || unq[0] != 17) begin
      bad++; $display("FAIL underrun_pulse count=%0d want 1 at 17", unq.size());
    end
    total++;
    if (abq.size() != 1 || abq[0] != 25) begin
      bad++; $display("FAIL underrun_aborted count=%0d want 1 at 25", abq.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    sel = 1;
    load(8'h01, 0); load(8'h02, 0); load(8'h04, 0); load(8'h08, 0); load(8'h10, 1);
    feed = 1'b1; drive();
    repeat (50) cycle();
    exp_s = {ONE, FLAG_S, bits8(8'h01), bits8(8'h02), bits8(8'h04), bits8(8'h08), ABT_S, ONE};
    total++;
    if (line != exp_s) begin bad++; $display("FAIL overflow_line got=%s want=%s", line, exp_s); end
    total++;
    if (rdyq[32] !== 1'b1 || rdyq[40] !== 1'b0) begin
      bad++; $display("FAIL overflow_ready got=%b%b want 10", rdyq[32], rdyq[40]);
    end
    total++;
    if (abq.size() != 1 || abq[0] != 49 || unq.size() != 0 || doneq.size() != 0) begin
      bad++; $display("FAIL overflow_pulses ab=%0d un=%0d done=%0d want 1 0 0", abq.size(), unq.size(), doneq.size());
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    sel = 0;
    load(8'hA5, 0); load(8'h5A, 1);
    feed = 1'b1; drive();
    for (int i = 0; i < 26; i++) begin
      Rst = (i == 12);
      if (i == 12) feed = 1'b0;
      cycle();
    end
    Rst = 1'b0;
    exp_s = {ONE, FLAG_S, "1010"};
    for (int i = 0; i < 13; i++) exp_s = {exp_s, ONE};
    total++;
    if (line != exp_s) begin bad++; $display("FAIL midreset_line got=%s want=%s", line, exp_s); end
    total++;
    if (abq.size() != 0 || busyq[13] !== 1'b0) begin
      bad++; $display("FAIL midreset_state aborted=%0d busy=%b want 0 0", abq.size(), busyq[13]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sel = 1;
    load(8'h7E, 0); load(8'h01, 1); load(8'hF8, 0); load(8'h03, 1);
    feed = 1'b1; drive();
    repeat (69) cycle();
    exp_s = {ONE, FLAG_S, "011111010", bits8(8'h01), FLAG_S, ONE,
             FLAG_S, "000111110", bits8(8'h03), FLAG_S, ONE};
    total++;
    if (line != exp_s) begin bad++; $display("FAIL b2b_line got=%s want=%s", line, exp_s); end
    total++;
    if (doneq.size() != 2 || doneq[0] != 34 || doneq[1] != 68) begin
      bad++; $display("FAIL b2b_done count=%0d want 2 at 34,68", doneq.size());
    end
    total++;
    if (abq.size() + unq.size() != 0) begin
      bad++; $display("FAIL b2b_errors count=%0d want 0", abq.size() + unq.size());
    end
  endtask

  initial begin
    Rst = 1'b1; TxEN = 1'b0; Tx_Valid = 1'b0; Tx_Last = 1'b0; Tx_Data = 8'h00;
    Tx_AbortFrame = 1'b0; sel = 0; feed = 0; hole = -1; pidx = 0; ncyc = 0;
    test_reset();
    test_fcs_frame();
    test_stuffing();
    test_abort();
    test_underrun();
    test_overflow();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
